// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Loader phases: header count, data bytes, single write cycle, terminal states.
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects accepted stream bytes little-endian into 32-bit words.
// The same assembler serves both the header count and the program words.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_reg;
  logic [23:0] asm_reg;

  // Byte counter and shift register; newest byte enters at the top so the
  // first byte of a word ends up in the least significant position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= 2'd0;
      asm_reg <= 24'd0;
    end else if (accept) begin
      cnt_reg <= cnt_reg + 2'd1;
      asm_reg <= {in_data, asm_reg[23:8]};
    end
  end

  // The fourth byte completes the word combinationally so the FSM can act on
  // it at the same edge that accepts it.
  always_comb begin
    word       = {in_data, asm_reg};
    word_valid = accept && (cnt_reg == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the
// CPU in reset until every word has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          WORDS     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] WORDS_W = 32'(WORDS);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] remaining_reg, remaining_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] word;
  logic        word_valid;
  logic        byte_fire;

  assign byte_fire = in_valid && in_ready;

  imem_loader_byte_assembler u_byte_assembler (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .accept     (byte_fire),
    .word       (word),
    .word_valid (word_valid)
  );

  // State, address, remaining-count and write-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= HDR;
      addr_reg      <= BASE_ADDR;
      remaining_reg <= 32'd0;
      wdata_reg     <= 32'd0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      wdata_reg     <= wdata_next;
    end
  end

  // Next-state logic; counters advance only when leaving WRITE.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    wdata_next     = wdata_reg;
    case (state_reg)
      HDR: begin
        if (word_valid) begin
          if (word == 32'd0) begin
            state_next = DONE;
          end else if (word > WORDS_W) begin
            state_next = ERROR;
          end else begin
            remaining_next = word;
            state_next     = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          wdata_next = word;
          state_next = WRITE;
        end
      end
      WRITE: begin
        addr_next      = addr_reg + 32'd4;
        remaining_next = remaining_reg - 32'd1;
        state_next     = (remaining_reg == 32'd1) ? DONE : DATA;
      end
      DONE, ERROR: begin
        if (reload) begin
          addr_next  = BASE_ADDR;
          state_next = HDR;
        end
      end
      default: state_next = HDR;
    endcase
  end

  // Outputs decode straight from the state register so they are glitch-free.
  always_comb begin
    in_ready         = (state_reg == HDR) || (state_reg == DATA);
    mem_write_enable = (state_reg == WRITE);
    mem_address      = addr_reg;
    mem_write_data   = wdata_reg;
    cpu_rst_n        = (state_reg == DONE);
    done             = (state_reg == DONE);
    error            = (state_reg == ERROR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams with hand-computed writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_mis = 0;
  int wr_n = 0;
  int low_n = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [7:0]  stim [$];
  int base_wr;
  int base_low;

  always #5 clk = ~clk;

  imem_loader #(.WORDS(64), .BASE_ADDR(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .reload           (reload),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .cpu_rst_n        (cpu_rst_n),
    .done             (done),
    .error            (error)
  );

  // Write-port monitor; also counts loading cycles with in_ready low.
  always @(negedge clk) begin
    if (mem_write_enable) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = mem_address;
        wr_data[wr_n] = mem_write_data;
      end
      wr_n = wr_n + 1;
      $display("WRITE addr=%08h data=%08h", mem_address, mem_write_data);
    end
    if (rst_n && !in_ready && !done && !error)
      low_n = low_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s = %08h", tag, obs);
    end
  endtask

  // Sends stim; returns at the negedge right after the last byte is accepted.
  task automatic play(input bit toggle);
    for (int i = 0; i < stim.size(); i++) begin
      int guard;
      if (toggle && i > 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_data  = stim[i];
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        chk("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;

    // Two-word program, continuous valid.
    base_wr  = wr_n;
    base_low = low_n;
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
    play(1'b0);
    chk("t1_we_last", 32'(mem_write_enable), 32'd1);
    chk("t1_addr_last", mem_address, 32'h4);
    chk("t1_data_last", mem_write_data, 32'h00100093);
    chk("t1_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("t1_we_off", 32'(mem_write_enable), 32'd0);
    chk("t1_ready_done", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("t1_nwrites", 32'(wr_n - base_wr), 32'd2);
    chk("t1_addr0", wr_addr[base_wr], 32'h0);
    chk("t1_data0", wr_data[base_wr], 32'h00500013);
    chk("t1_addr1", wr_addr[base_wr + 1], 32'h4);
    chk("t1_data1", wr_data[base_wr + 1], 32'h00100093);
    chk("t1_ready_low", 32'(low_n - base_low), 32'd2);

    // Same program with in_valid toggling every cycle.
    do_reset();
    base_wr  = wr_n;
    base_low = low_n;
    play(1'b1);
    repeat (3) @(negedge clk);
    chk("t2_nwrites", 32'(wr_n - base_wr), 32'd2);
    chk("t2_addr0", wr_addr[base_wr], 32'h0);
    chk("t2_data0", wr_data[base_wr], 32'h00500013);
    chk("t2_addr1", wr_addr[base_wr + 1], 32'h4);
    chk("t2_data1", wr_data[base_wr + 1], 32'h00100093);
    chk("t2_ready_low", 32'(low_n - base_low), 32'd2);
    chk("t2_done", 32'(done), 32'd1);

    // Reload from DONE, then a one-word program.
    pulse_reload();
    chk("t6_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("t6_done_clr", 32'(done), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_addr", mem_address, 32'h0);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    play(1'b0);
    chk("t6_we", 32'(mem_write_enable), 32'd1);
    chk("t6_waddr", mem_address, 32'h0);
    chk("t6_wdata", mem_write_data, 32'h12345678);
    @(negedge clk);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_cpu_up", 32'(cpu_rst_n), 32'd1);

    // Zero-length header goes straight to DONE.
    do_reset();
    base_wr = wr_n;
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    play(1'b0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("t3_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_nwrites", 32'(wr_n - base_wr), 32'd0);

    // Oversized header (65) lands in ERROR until reload.
    do_reset();
    base_wr = wr_n;
    stim = '{8'h41, 8'h00, 8'h00, 8'h00};
    play(1'b0);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("t4_ready", 32'(in_ready), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_error_hold", 32'(error), 32'd1);
    chk("t4_nwrites", 32'(wr_n - base_wr), 32'd0);
    pulse_reload();
    chk("t4_error_clr", 32'(error), 32'd0);
    chk("t4_ready_hdr", 32'(in_ready), 32'd1);

    // Header exactly WORDS (64) is legal.
    do_reset();
    stim = '{8'h40, 8'h00, 8'h00, 8'h00};
    play(1'b0);
    chk("tb_max_error", 32'(error), 32'd0);
    chk("tb_max_ready", 32'(in_ready), 32'd1);

    // Reset mid-word discards the partial word.
    do_reset();
    base_wr = wr_n;
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE};
    play(1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_nwrites", 32'(wr_n - base_wr), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    play(1'b0);
    chk("t5_we", 32'(mem_write_enable), 32'd1);
    chk("t5_waddr", mem_address, 32'h0);
    chk("t5_wdata", mem_write_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("t5_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
